// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, encodings and byte-lane helpers used by the memory master
// and by any slave-side model that needs the same lane placement.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'd0,
    MEM_HALF    = 2'd1,
    MEM_WORD    = 2'd2,
    MEM_ILLEGAL = 2'd3
  } mem_size_t;

  // A request is legal when the size is encodable and the address is naturally aligned.
  function automatic logic mem_req_legal(mem_size_t size, logic [1:0] addr_lo);
    logic ok;
    case (size)
      MEM_BYTE: ok = 1'b1;
      MEM_HALF: ok = ~addr_lo[0];
      MEM_WORD: ok = (addr_lo == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Store data is replicated across all lanes so the slave can pick any byte/half lane.
  function automatic logic [31:0] ahb_wlane(mem_size_t size, logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      MEM_BYTE: lanes = {4{wdata[7:0]}};
      MEM_HALF: lanes = {2{wdata[15:0]}};
      default:  lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] ahb_rlane(mem_size_t size, logic [1:0] addr_lo,
                                            logic [31:0] hrdata);
    logic [31:0] val;
    case (size)
      MEM_BYTE: begin
        case (addr_lo)
          2'd0:    val = {24'h0, hrdata[7:0]};
          2'd1:    val = {24'h0, hrdata[15:8]};
          2'd2:    val = {24'h0, hrdata[23:16]};
          default: val = {24'h0, hrdata[31:24]};
        endcase
      end
      MEM_HALF: val = addr_lo[1] ? {16'h0, hrdata[31:16]} : {16'h0, hrdata[15:0]};
      default:  val = hrdata;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/ahb_mem_master_if.sv
// AHB-Lite bus bundle between the memory master and the interconnect.
interface ahb_mem_master_if #(
  parameter int ADDR_WIDTH = 32
) ();
  import ahb_pkg::*;

  logic [ADDR_WIDTH-1:0] HADDR;
  htrans_t               HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [31:0]           HWDATA;
  logic [31:0]           HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_mem_master.sv
// Single-transfer AHB-Lite master: turns one core memory request into one NONSEQ
// transfer and returns lane-extracted read data with a one-cycle done pulse.
module ahb_mem_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic [1:0]            dbg_state,
  ahb_mem_master_if.master      ahb
);

  // Handshake: the core raises req only while busy=0 and holds off until done;
  // done/err/rdata form a one-cycle valid with no back-pressure. On the bus side a
  // phase advances only on a cycle where HREADY=1.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERRW = 2'd3
  } state_t;

  state_t                state_q, state_d;
  htrans_t               htrans_d;
  logic [ADDR_WIDTH-1:0] haddr_d;
  logic                  hwrite_d;
  logic [2:0]            hsize_d;
  logic [31:0]           hwdata_d;
  logic                  done_d, err_d;
  logic [31:0]           rdata_d;

  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;
  assign ahb.HBURST = HBURST_SINGLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    htrans_d = HTRANS_IDLE;
    haddr_d  = ahb.HADDR;
    hwrite_d = ahb.HWRITE;
    hsize_d  = ahb.HSIZE;
    hwdata_d = ahb.HWDATA;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (mem_req_legal(mem_size_t'(size), addr[1:0])) begin
            state_d  = ST_ADDR;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = addr;
            hwrite_d = we;
            hsize_d  = {1'b0, size};
            hwdata_d = ahb_wlane(mem_size_t'(size), wdata);
          end else begin
            // Rejected locally: the bus never sees it.
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end
        end
      end

      ST_ADDR: begin
        if (ahb.HREADY) state_d  = ST_DATA;
        else            htrans_d = HTRANS_NONSEQ;
      end

      ST_DATA: begin
        if (ahb.HRESP == HRESP_ERROR) begin
          // A slave that collapses the two error cycles into one is still honoured.
          if (ahb.HREADY) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ST_ERRW;
          end
        end else if (ahb.HREADY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          rdata_d = ahb.HWRITE ? 32'h0
                  : ahb_rlane(mem_size_t'(ahb.HSIZE[1:0]), ahb.HADDR[1:0], ahb.HRDATA);
        end
      end

      ST_ERRW: begin
        if (ahb.HREADY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ahb.HTRANS <= HTRANS_IDLE;
      ahb.HADDR  <= '0;
      ahb.HWRITE <= 1'b0;
      ahb.HSIZE  <= 3'b000;
      ahb.HWDATA <= 32'h0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'h0;
    end else begin
      ahb.HTRANS <= htrans_d;
      ahb.HADDR  <= haddr_d;
      ahb.HWRITE <= hwrite_d;
      ahb.HSIZE  <= hsize_d;
      ahb.HWDATA <= hwdata_d;
      done       <= done_d;
      err        <= err_d;
      rdata      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_mem_master.sv
// Bench for ahb_mem_master: directed vector table, reset-in-flight sequence and
// randomized transfers against a slave model and an arithmetic reference model.
module tb_ahb_mem_master;
  import ahb_pkg::*;

  logic        clk;
  logic        reset;
  logic        req, we;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    int          aw;
    int          dw;
    logic        eresp;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_hwdata;
  } vec_t;

  ahb_mem_master_if #(.ADDR_WIDTH(32)) bus ();

  ahb_mem_master #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .dbg_state (dbg_state),
    .ahb       (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: outcome of one request computed from the protocol rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   illegal;
    int   sh;
    r       = v;
    illegal = (v.size == 2'd3) || (v.size == 2'd1 && v.addr[0]) ||
              (v.size == 2'd2 && v.addr[1:0] != 2'b00);
    sh      = 8 * int'(v.addr[1:0]);
    case (v.size)
      2'd0:    r.exp_hwdata = {24'h0, v.wdata[7:0]} * 32'h01010101;
      2'd1:    r.exp_hwdata = {16'h0, v.wdata[15:0]} * 32'h00010001;
      default: r.exp_hwdata = v.wdata;
    endcase
    if (illegal) begin
      r.exp_cyc   = 1;
      r.exp_err   = 1'b1;
      r.exp_rdata = 32'h0;
    end else begin
      r.exp_cyc = 3 + v.aw + v.dw + (v.eresp ? 1 : 0);
      r.exp_err = v.eresp;
      if (v.eresp || v.we)    r.exp_rdata = 32'h0;
      else if (v.size == 2'd0) r.exp_rdata = (v.hrdata >> sh) & 32'h000000FF;
      else if (v.size == 2'd1) r.exp_rdata = (v.hrdata >> sh) & 32'h0000FFFF;
      else                     r.exp_rdata = v.hrdata;
    end
    return r;
  endfunction

  // Driver + slave model: called at a negedge; returns at the negedge where done is seen.
  task automatic run_xfer(input vec_t v);
    int  cyc;
    int  aw, dw, estage;
    bit  in_data, got, legal;
    legal = (v.exp_cyc != 1);
    exp_q.push_back(v.exp_rdata);
    req        = 1'b1;
    we         = v.we;
    size       = v.size;
    addr       = v.addr;
    wdata      = v.wdata;
    bus.HRDATA = v.hrdata;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    aw = v.aw; dw = v.dw; estage = 0; in_data = 0; got = 0;
    @(negedge clk);
    req   = 1'b0;
    we    = 1'($urandom);
    size  = 2'($urandom);
    addr  = $urandom;
    wdata = $urandom;
    for (cyc = 1; cyc < 40; cyc++) begin
      if (done) begin
        got = 1;
        break;
      end
      check("busy_active", busy, legal);
      if (!legal) begin
        check("htrans_illegal", bus.HTRANS, HTRANS_IDLE);
      end else if (!in_data) begin
        if (bus.HTRANS == HTRANS_NONSEQ) begin
          if (cyc == 1) begin
            check("haddr", bus.HADDR, v.addr);
            check("hwrite", bus.HWRITE, v.we);
            check("hsize", bus.HSIZE, {1'b0, v.size});
            check("hburst", bus.HBURST, 32'h0);
          end
          if (aw > 0) begin
            bus.HREADY = 1'b0;
            aw--;
          end else begin
            bus.HREADY = 1'b1;
            in_data    = 1;
          end
        end else begin
          bus.HREADY = 1'b1;
        end
      end else begin
        check("htrans_data", bus.HTRANS, HTRANS_IDLE);
        if (v.we) check("hwdata", bus.HWDATA, v.exp_hwdata);
        if (v.eresp && dw == 0) begin
          bus.HRESP  = 1'b1;
          bus.HREADY = (estage == 1);
          estage++;
        end else if (dw > 0) begin
          bus.HREADY = 1'b0;
          bus.HRESP  = 1'b0;
          dw--;
        end else begin
          bus.HREADY = 1'b1;
        end
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done expected_cycle=%0d addr=0x%08h", v.exp_cyc, v.addr);
      void'(exp_q.pop_front());
    end else begin
      check("done_cycle", cyc, v.exp_cyc);
      check("err", err, v.exp_err);
      check("busy_at_done", busy, 1'b0);
      check("rdata", rdata, exp_q.pop_front());
    end
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    req = 0; we = 0; size = 0; addr = 0; wdata = 0;
    bus.HRDATA = 32'h0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;

    // reset values
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_htrans", bus.HTRANS, HTRANS_IDLE);
    check("rst_haddr", bus.HADDR, 32'h0);
    check("rst_hwrite", bus.HWRITE, 1'b0);
    check("rst_hsize", bus.HSIZE, 32'h0);
    check("rst_hburst", bus.HBURST, 32'h0);
    check("rst_hwdata", bus.HWDATA, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_state", dbg_state, 2'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // directed table: we size addr wdata hrdata aw dw eresp | cyc err rdata hwdata
    tbl[0]  = '{1'b0, 2'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 3, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b1, 2'd0, 32'h203, 32'h5A, 32'h0, 0, 2, 1'b0, 5, 1'b0, 32'h0, 32'h5A5A5A5A};
    tbl[2]  = '{1'b0, 2'd1, 32'h2, 32'h0, 32'h12345678, 0, 0, 1'b0, 3, 1'b0, 32'h00001234, 32'h0};
    tbl[3]  = '{1'b0, 2'd2, 32'h40, 32'h0, 32'hFFFFFFFF, 0, 0, 1'b1, 4, 1'b1, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 2'd2, 32'h6, 32'h0, 32'h0, 0, 0, 1'b0, 1, 1'b1, 32'h0, 32'h0};
    tbl[5]  = '{1'b0, 2'd0, 32'h1, 32'h0, 32'hA1B2C3D4, 1, 0, 1'b0, 4, 1'b0, 32'h000000C3, 32'h0};
    tbl[6]  = '{1'b1, 2'd1, 32'h12, 32'hFFFFBEEF, 32'h0, 1, 1, 1'b0, 5, 1'b0, 32'h0, 32'hBEEFBEEF};
    tbl[7]  = '{1'b0, 2'd3, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0, 1, 1'b1, 32'h0, 32'h0};
    tbl[8]  = '{1'b1, 2'd1, 32'h1, 32'h0, 32'h0, 0, 0, 1'b0, 1, 1'b1, 32'h0, 32'h0};
    tbl[9]  = '{1'b0, 2'd0, 32'h3, 32'h0, 32'h89ABCDEF, 0, 0, 1'b0, 3, 1'b0, 32'h00000089, 32'h0};
    tbl[10] = '{1'b1, 2'd2, 32'h80, 32'h01234567, 32'h0, 1, 1, 1'b1, 6, 1'b1, 32'h0, 32'h01234567};

    @(negedge clk);
    for (int i = 0; i < 11; i++) run_xfer(tbl[i]);

    // reset dropped during a stalled data phase of a write
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h44; wdata = 32'hCAFEF00D;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    bus.HREADY = 1'b0;
    check("mid_busy", busy, 1'b1);
    check("mid_hwrite", bus.HWRITE, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_htrans", bus.HTRANS, HTRANS_IDLE);
    check("arst_busy", busy, 1'b0);
    check("arst_hwrite", bus.HWRITE, 1'b0);
    check("arst_haddr", bus.HADDR, 32'h0);
    check("arst_hwdata", bus.HWDATA, 32'h0);
    check("arst_done", done, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("arst_no_done", done, 1'b0);
    end
    reset = 1'b1;
    bus.HREADY = 1'b1;
    run_xfer(tbl[2]);

    // randomized transfers, back to back
    for (int i = 0; i < 60; i++) begin
      rv.we     = 1'($urandom);
      rv.size   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rv.addr   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rv.size == 2'd1) rv.addr[0] = 1'b0;
        if (rv.size == 2'd2) rv.addr[1:0] = 2'b00;
      end
      rv.wdata  = $urandom;
      rv.hrdata = $urandom;
      rv.aw     = $urandom_range(0, 2);
      rv.dw     = $urandom_range(0, 2);
      rv.eresp  = ($urandom_range(0, 5) == 0);
      rv = model(rv);
      run_xfer(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
